// File: rtl/i2c_slave_data_path_block.sv
// -----------------------------------------------------------------------------
// i2c_slave_data_path_block
//
// I2C target (slave) bit-level engine. It oversamples SCL/SDA on the core
// clock, detects START / repeated START / STOP, matches a 7-bit address,
// ACKs it, and then shifts write bytes in or read bytes out. SDA is driven
// open-drain: sda_oe_o=1 pulls the line low, 0 releases it. SCL is never
// stretched.
//
// Ports
//   i2c_core_clock_i  in   core clock, all logic on posedge
//   reset_bit_n_i     in   asynchronous active-low reset
//   scl_i, sda_i      in   raw bus pins (asynchronous to the core clock)
//   slave_addr_i      in   [6:0] own address, quasi-static
//   tx_data_i         in   [7:0] read-return byte, sampled on the tx_load_o cycle
//   rx_full_i         in   1 = upper layer cannot take a byte (write ACK slot NACKs)
//   sda_oe_o          out  1 = pull SDA low
//   rx_data_o         out  [7:0] last received write byte
//   rx_valid_o        out  1-cycle pulse when rx_data_o updates
//   tx_load_o         out  1-cycle pulse when tx_data_i is captured
//   rw_o              out  R/W bit of the last matched address (1 = read)
//   busy_o            out  1 from START until STOP
//   addr_match_o      out  1 from the matched-address ACK until STOP / repeated START
//
// Parameter
//   SDA_HOLD_CYCLES   core clocks from detected SCL fall to an SDA drive change (1..15)
// -----------------------------------------------------------------------------
module i2c_slave_data_path_block #(
  parameter int unsigned SDA_HOLD_CYCLES = 1
) (
  input  logic       i2c_core_clock_i,
  input  logic       reset_bit_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic [6:0] slave_addr_i,
  input  logic [7:0] tx_data_i,
  input  logic       rx_full_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_load_o,
  output logic       rw_o,
  output logic       busy_o,
  output logic       addr_match_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_DATA,
    ST_RX_ACK,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_IGNORE
  } state_e;

  localparam logic [3:0] HOLD_LOAD = 4'(SDA_HOLD_CYCLES);

  // ---------------------------------------------------------------------------
  // Input path: 2-flop synchronizer plus one delay register for edge detect.
  // Reset to 1 (idle bus level) so reset release never looks like an event.
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_dly_q, sda_dly_q;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset, so every flop sees pre-edge values of its neighbours.
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
    if (!reset_bit_n_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_dly_q  <= scl_sync_q[1];
      sda_dly_q  <= sda_sync_q[1];
    end
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  =  scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s &  scl_dly_q;
  // SDA may only change while SCL is low; a change with SCL high on both
  // samples is a bus condition, not data.
  assign start_det = scl_s & scl_dly_q &  sda_dly_q & ~sda_s;
  assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q &  sda_s;

  // ---------------------------------------------------------------------------
  // Hold counter: an SDA drive change is allowed SDA_HOLD_CYCLES after the
  // detected SCL fall, giving the master's SCL low a clean hold margin.
  // ---------------------------------------------------------------------------
  logic [3:0] hold_q, hold_d;
  logic       drive_upd;

  always_comb begin
    hold_d = hold_q;
    if (scl_fall) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != 4'd0) begin
      hold_d = hold_q - 4'd1;
    end
  end

  assign drive_upd = (hold_q == 4'd1);

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
    if (!reset_bit_n_i) begin
      hold_q <= 4'd0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  // Marks "the SCL rise of the current 9th/ACK slot (or last TX bit) has
  // been seen", which tells the next drive update to end the slot.
  logic       slot_rise_q, slot_rise_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       addr_match_q, addr_match_d;

  logic [7:0] shift_in;
  assign shift_in = {shift_q[6:0], sda_s};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    slot_rise_d  = slot_rise_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    tx_load_d    = 1'b0;
    rw_d         = rw_q;
    busy_d       = busy_q;
    addr_match_d = addr_match_q;

    if (stop_det) begin
      // A partial byte is simply dropped with the shift contents.
      state_d      = ST_IDLE;
      bit_cnt_d    = 3'd7;
      slot_rise_d  = 1'b0;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b0;
      addr_match_d = 1'b0;
    end else if (start_det) begin
      state_d      = ST_ADDR;
      bit_cnt_d    = 3'd7;
      slot_rise_d  = 1'b0;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b1;
      addr_match_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_IGNORE: begin
          // Only bus conditions (handled above) leave these states.
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == 3'd0) begin
              bit_cnt_d = 3'd7;
              if (shift_in[7:1] == slave_addr_i) begin
                rw_d        = shift_in[0];
                slot_rise_d = 1'b0;
                state_d     = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_rise) begin
            slot_rise_d = 1'b1;
          end else if (drive_upd) begin
            if (!slot_rise_q) begin
              sda_oe_d     = 1'b1;
              addr_match_d = 1'b1;
            end else begin
              slot_rise_d = 1'b0;
              bit_cnt_d   = 3'd7;
              if (rw_q) begin
                // The read byte's MSB replaces the ACK in the same update.
                tx_load_d = 1'b1;
                shift_d   = tx_data_i;
                sda_oe_d  = ~tx_data_i[7];
                state_d   = ST_TX_DATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_RX_DATA;
              end
            end
          end
        end

        ST_RX_DATA: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == 3'd0) begin
              rx_data_d   = shift_in;
              rx_valid_d  = 1'b1;
              bit_cnt_d   = 3'd7;
              slot_rise_d = 1'b0;
              state_d     = ST_RX_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end

        ST_RX_ACK: begin
          if (scl_rise) begin
            slot_rise_d = 1'b1;
          end else if (drive_upd) begin
            if (!slot_rise_q) begin
              sda_oe_d = ~rx_full_i;
            end else begin
              sda_oe_d    = 1'b0;
              slot_rise_d = 1'b0;
              state_d     = ST_RX_DATA;
            end
          end
        end

        ST_TX_DATA: begin
          // bit_cnt_q indexes the bit currently on the bus.
          if (scl_rise) begin
            if (bit_cnt_q == 3'd0) begin
              slot_rise_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else if (drive_upd) begin
            if (slot_rise_q) begin
              sda_oe_d    = 1'b0;
              slot_rise_d = 1'b0;
              state_d     = ST_TX_ACK;
            end else begin
              sda_oe_d = ~shift_q[bit_cnt_q];
            end
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              slot_rise_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (drive_upd && slot_rise_q) begin
            tx_load_d   = 1'b1;
            shift_d     = tx_data_i;
            sda_oe_d    = ~tx_data_i[7];
            bit_cnt_d   = 3'd7;
            slot_rise_d = 1'b0;
            state_d     = ST_TX_DATA;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
    if (!reset_bit_n_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd7;
      shift_q      <= 8'h00;
      slot_rise_q  <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      tx_load_q    <= 1'b0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
      addr_match_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      slot_rise_q  <= slot_rise_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_load_q    <= tx_load_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
      addr_match_q <= addr_match_d;
    end
  end

  assign sda_oe_o     = sda_oe_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign tx_load_o    = tx_load_q;
  assign rw_o         = rw_q;
  assign busy_o       = busy_q;
  assign addr_match_o = addr_match_q;

endmodule

// File: tb/tb_i2c_slave_data_path_block.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_data_path_block
//
// Directed bench: a behavioural I2C master (40 core clocks per SCL bit) talks
// to the slave over a wired-AND SDA line. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_i2c_slave_data_path_block;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       master_sda;
  logic       sda_bus;
  logic [6:0] slave_addr;
  logic [7:0] tx_data;
  logic       rx_full;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_load;
  logic       rw;
  logic       busy;
  logic       addr_match;

  always #5 clk = ~clk;

  // Open-drain bus: either side pulling low wins.
  assign sda_bus = master_sda & ~sda_oe;

  i2c_slave_data_path_block #(.SDA_HOLD_CYCLES(1)) dut (
    .i2c_core_clock_i (clk),
    .reset_bit_n_i    (rst_n),
    .scl_i            (scl),
    .sda_i            (sda_bus),
    .slave_addr_i     (slave_addr),
    .tx_data_i        (tx_data),
    .rx_full_i        (rx_full),
    .sda_oe_o         (sda_oe),
    .rx_data_o        (rx_data),
    .rx_valid_o       (rx_valid),
    .tx_load_o        (tx_load),
    .rw_o             (rw),
    .busy_o           (busy),
    .addr_match_o     (addr_match)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cumulative event monitors; tests compare snapshots taken before and after.
  int rx_valid_cnt = 0;
  int tx_load_cnt  = 0;
  int oe_cyc       = 0;
  int match_cyc    = 0;

  always @(negedge clk) begin
    if (rx_valid)   rx_valid_cnt <= rx_valid_cnt + 1;
    if (tx_load)    tx_load_cnt  <= tx_load_cnt + 1;
    if (sda_oe)     oe_cyc       <= oe_cyc + 1;
    if (addr_match) match_cyc    <= match_cyc + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL bit: SDA set mid-low, bus sampled mid-high. Returns just after SCL falls.
  task automatic clock_bit(input logic b, output logic smp);
    wait_cyc(10);
    master_sda = b;
    wait_cyc(10);
    scl = 1'b1;
    wait_cyc(10);
    smp = sda_bus;
    wait_cyc(10);
    scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_n);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack_n);
  endtask

  task automatic read_byte(input logic ack_n, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(ack_n, s);
  endtask

  // START from an idle bus, or repeated START when SCL is currently low.
  task automatic start_cond();
    if (scl == 1'b0) begin
      wait_cyc(10);
      master_sda = 1'b1;
      wait_cyc(10);
      scl = 1'b1;
      wait_cyc(10);
    end
    master_sda = 1'b0;
    wait_cyc(20);
    scl = 1'b0;
  endtask

  task automatic stop_cond(input bit chk_busy);
    wait_cyc(10);
    master_sda = 1'b0;
    wait_cyc(10);
    scl = 1'b1;
    wait_cyc(10);
    master_sda = 1'b1;
    if (chk_busy) begin
      wait_cyc(2);
      check("busy_2cyc_after_stop", 32'(busy), 32'd1);
      wait_cyc(1);
      check("busy_3cyc_after_stop", 32'(busy), 32'd0);
      wait_cyc(17);
    end else begin
      wait_cyc(20);
    end
  endtask

  initial begin
    logic       ack_n;
    logic       s;
    logic [7:0] b;
    logic [7:0] addr_w;
    int         rv0, tl0, oe0, m0;

    rst_n      = 1'b0;
    scl        = 1'b1;
    master_sda = 1'b1;
    slave_addr = 7'h42;
    tx_data    = 8'h00;
    rx_full    = 1'b0;
    wait_cyc(3);
    check("reset_outputs", 32'({sda_oe, rx_data, rx_valid, tx_load, rw, busy, addr_match}), 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // ---- Write 0x42+W, 0x5A, STOP ----
    rv0 = rx_valid_cnt;
    start_cond();
    check("busy_after_start", 32'(busy), 32'd1);
    write_byte(8'h84, ack_n);
    check("wr_addr_ack", 32'(ack_n), 32'd0);
    check("wr_addr_match", 32'(addr_match), 32'd1);
    check("wr_rw", 32'(rw), 32'd0);
    write_byte(8'h5A, ack_n);
    check("wr_data_ack", 32'(ack_n), 32'd0);
    check("wr_rx_data", 32'(rx_data), 32'h5A);
    check("wr_rx_valid_pulses", 32'(rx_valid_cnt - rv0), 32'd1);
    stop_cond(1'b1);
    check("wr_match_after_stop", 32'(addr_match), 32'd0);

    // ---- Read 0x42+R: 0xC3 (ACK), 0x81 (NACK) ----
    tx_data = 8'hC3;
    tl0 = tx_load_cnt;
    rv0 = rx_valid_cnt;
    start_cond();
    write_byte(8'h85, ack_n);
    check("rd_addr_ack", 32'(ack_n), 32'd0);
    check("rd_rw", 32'(rw), 32'd1);
    read_byte(1'b0, b);
    check("rd_byte0", 32'(b), 32'hC3);
    tx_data = 8'h81;
    read_byte(1'b1, b);
    check("rd_byte1", 32'(b), 32'h81);
    check("rd_tx_load_pulses", 32'(tx_load_cnt - tl0), 32'd2);
    check("rd_no_rx_valid", 32'(rx_valid_cnt - rv0), 32'd0);
    wait_cyc(10);
    check("rd_released_after_nack", 32'(sda_oe), 32'd0);
    oe0 = oe_cyc;
    stop_cond(1'b0);
    check("rd_no_drive_after_nack", 32'(oe_cyc - oe0), 32'd0);

    // ---- Address mismatch 0x43+W ----
    oe0 = oe_cyc;
    rv0 = rx_valid_cnt;
    m0  = match_cyc;
    start_cond();
    write_byte(8'h86, ack_n);
    check("mm_addr_nack", 32'(ack_n), 32'd1);
    write_byte(8'h55, ack_n);
    check("mm_data_nack", 32'(ack_n), 32'd1);
    stop_cond(1'b0);
    check("mm_sda_never_driven", 32'(oe_cyc - oe0), 32'd0);
    check("mm_no_rx_valid", 32'(rx_valid_cnt - rv0), 32'd0);
    check("mm_no_addr_match", 32'(match_cyc - m0), 32'd0);

    // ---- Repeated START: write 0x10, Sr, read 0xA5 ----
    tx_data = 8'hA5;
    start_cond();
    write_byte(8'h84, ack_n);
    check("sr_wr_addr_ack", 32'(ack_n), 32'd0);
    write_byte(8'h10, ack_n);
    check("sr_wr_data_ack", 32'(ack_n), 32'd0);
    check("sr_rx_data", 32'(rx_data), 32'h10);
    start_cond();
    check("sr_match_cleared", 32'(addr_match), 32'd0);
    write_byte(8'h85, ack_n);
    check("sr_rd_addr_ack", 32'(ack_n), 32'd0);
    check("sr_rw", 32'(rw), 32'd1);
    check("sr_addr_match", 32'(addr_match), 32'd1);
    read_byte(1'b1, b);
    check("sr_rd_byte", 32'(b), 32'hA5);
    stop_cond(1'b0);

    // ---- STOP after 4 data bits ----
    start_cond();
    write_byte(8'h84, ack_n);
    check("part_addr_ack", 32'(ack_n), 32'd0);
    rv0 = rx_valid_cnt;
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    stop_cond(1'b0);
    check("part_no_rx_valid", 32'(rx_valid_cnt - rv0), 32'd0);
    check("part_sda_oe", 32'(sda_oe), 32'd0);
    check("part_busy", 32'(busy), 32'd0);
    check("part_rx_data_kept", 32'(rx_data), 32'h10);

    // ---- rx_full during a write byte ----
    start_cond();
    write_byte(8'h84, ack_n);
    check("full_addr_ack", 32'(ack_n), 32'd0);
    rx_full = 1'b1;
    rv0 = rx_valid_cnt;
    write_byte(8'h3C, ack_n);
    check("full_data_nack", 32'(ack_n), 32'd1);
    check("full_rx_valid_pulses", 32'(rx_valid_cnt - rv0), 32'd1);
    check("full_rx_data", 32'(rx_data), 32'h3C);
    rx_full = 1'b0;
    stop_cond(1'b0);

    // ---- Async reset while driving the address ACK ----
    start_cond();
    addr_w = 8'h84;
    for (int i = 7; i >= 0; i--) clock_bit(addr_w[i], s);
    wait_cyc(10);
    master_sda = 1'b1;
    wait_cyc(10);
    scl = 1'b1;
    wait_cyc(5);
    check("rst_ack_driving", 32'(sda_oe), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'({sda_oe, rx_data, rx_valid, tx_load, rw, busy, addr_match}), 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    scl = 1'b0;
    stop_cond(1'b0);

    // ---- A normal write still works after reset ----
    start_cond();
    write_byte(8'h84, ack_n);
    check("post_rst_addr_ack", 32'(ack_n), 32'd0);
    write_byte(8'hE7, ack_n);
    check("post_rst_rx_data", 32'(rx_data), 32'hE7);
    stop_cond(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
